subpixel_interp_8x8: RTL and testbench

Computes all 15 HEVC luma fractional-sample positions for one 8x8 block from a 15x15 window of 8-bit integer pixels. Rows are fetched one per clock from an external row store addressed by `next_row`. 8-tap quarter, half and three-quarter filters run first horizontally on each row, then vertically over the buffered results. The block sits between the reference-frame row buffer and the motion-compensation consumer.

---
 rtl/subpix_pkg.sv | 45 ++++
 rtl/subpix_fir8.sv | 28 ++
 rtl/subpixel_interp_8x8.sv | 154 +++++++++++++++
 tb/tb_subpixel_interp_8x8.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/subpix_pkg.sv
// rtl/subpix_pkg.sv - shared sizes, phase enum, coefficient tables and product helper for subpixel_interp_8x8
// Contents: TAPS/WIN/BLK/PIX_W/ACC_W sizes, phase_e {PH_A, PH_B, PH_C}, COEF_A/B/C tables,
//           coef() tap lookup, cmul() signed coefficient x pixel product.
// Build option SUBPIX_MULTIPLIERLESS_EN: when defined, cmul() forms every product from shifts and adds.
package subpix_pkg;
    localparam int TAPS  = 8;
    localparam int WIN   = 15;
    localparam int BLK   = 8;
    localparam int PIX_W = 8;
    localparam int ACC_W = 17;

    typedef enum logic [1:0] {PH_A, PH_B, PH_C} phase_e;

    localparam int COEF_A [TAPS] = '{-1, 4, -10, 58, 17,  -5, 1,  0};
    localparam int COEF_B [TAPS] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    localparam int COEF_C [TAPS] = '{ 0, 1,  -5, 17, 58, -10, 4, -1};

    function automatic int coef(input phase_e ph, input int t);
        case (ph)
            PH_A:    return COEF_A[t];
            PH_B:    return COEF_B[t];
            default: return COEF_C[t];
        endcase
    endfunction

    // Coefficients are constants at every call site, so either form reduces to fixed wiring.
    function automatic logic signed [ACC_W-1:0] cmul(input int c, input logic [PIX_W-1:0] x);
        int xi;
        int p;
`ifdef SUBPIX_MULTIPLIERLESS_EN
        int m;
`endif
        xi = int'(x);
`ifdef SUBPIX_MULTIPLIERLESS_EN
        m = (c < 0) ? -c : c;
        p = 0;
        for (int b = 0; b < 7; b++)
            if (m[b]) p = p + (xi << b);
        if (c < 0) p = -p;
`else
        p = c * xi;
`endif
        return p[ACC_W-1:0];
    endfunction
endpackage

// File: rtl/subpix_fir8.sv
// rtl/subpix_fir8.sv - one 8-tap fractional-sample filter with rounding and 0..255 clipping
// Parameter: PH  - filter phase (PH_A quarter, PH_B half, PH_C three-quarter)
// Ports:     x_i - eight 8-bit samples, tap t = x_i[8t+7:8t]
//            y_o - clip((sum + 32) >>> 6, 0, 255)
module subpix_fir8
    import subpix_pkg::*;
#(
    parameter phase_e PH = PH_A
) (
    input  logic [TAPS*PIX_W-1:0] x_i,
    output logic [PIX_W-1:0]      y_o
);
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;

    always_comb begin
        sum = '0;
        for (int t = 0; t < TAPS; t++)
            sum = sum + cmul(coef(PH, t), x_i[PIX_W*t +: PIX_W]);
        rnd = (sum + $signed(ACC_W'(32))) >>> 6;
        if (rnd < 0)
            y_o = '0;
        else if (rnd > $signed(ACC_W'(255)))
            y_o = '1;
        else
            y_o = rnd[PIX_W-1:0];
    end
endmodule

// File: rtl/subpixel_interp_8x8.sv
// rtl/subpixel_interp_8x8.sv - HEVC luma 15-position sub-pixel interpolator for one 8x8 block
// Ports: clk, rst (async active-high); in_row (15 pixels of row next_row); next_row (row request 0..14);
//        out_A/B/C (five 8x8 blocks each); cnt (phase counter 0..23); fir_out_a/b/c (current row horizontal);
//        temp_A/B/C (15x8 horizontal buffers); load_out (results complete); sel (output row being written);
//        currentPixels (last captured in_row).
// Build option SUBPIX_MULTIPLIERLESS_EN selects shift-add coefficient products (see subpix_pkg).
module subpixel_interp_8x8
    import subpix_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [119:0]  in_row,
    output logic [63:0]   next_row,
    output logic [2559:0] out_A,
    output logic [2559:0] out_B,
    output logic [2559:0] out_C,
    output logic [7:0]    cnt,
    output logic [63:0]   fir_out_a,
    output logic [63:0]   fir_out_b,
    output logic [63:0]   fir_out_c,
    output logic [959:0]  temp_A,
    output logic [959:0]  temp_B,
    output logic [959:0]  temp_C,
    output logic          load_out,
    output logic [7:0]    sel,
    output logic [119:0]  currentPixels
);
    localparam int ROW_W   = BLK * PIX_W;
    localparam int BUF_W   = WIN * ROW_W;
    localparam int BLOCK_W = BLK * ROW_W;
    localparam int OUT_W   = 5 * BLOCK_W;
    localparam logic [7:0] CNT_V_FIRST = 8'(WIN);
    localparam logic [7:0] CNT_DONE    = 8'(WIN + BLK);

    logic [7:0]       cnt_q, cnt_d;
    logic [BUF_W-1:0] temp_q [3];
    logic [BUF_W-1:0] temp_d [3];
    logic [BUF_W-1:0] ibuf_q, ibuf_d;
    logic [OUT_W-1:0] out_q [3];
    logic [OUT_W-1:0] out_d [3];
    logic [119:0]     cur_q, cur_d;

    logic       hphase, vphase;
    logic [3:0] hrow, vrow;

    assign hphase = (cnt_q < CNT_V_FIRST);
    assign vphase = !hphase && (cnt_q < CNT_DONE);
    // After the last row is fetched the request stays parked on row 14.
    assign hrow   = hphase ? cnt_q[3:0] : 4'(WIN - 1);
    assign vrow   = vphase ? 4'(cnt_q - CNT_V_FIRST) : 4'd0;

    // Horizontal pass: output j of each phase reads pixels j..j+7 of the current row.
    logic [ROW_W-1:0] h_row [3];
    for (genvar p = 0; p < 3; p++) begin : g_hph
        for (genvar j = 0; j < BLK; j++) begin : g_hcol
            subpix_fir8 #(.PH(phase_e'(p))) u_fir (
                .x_i (in_row[PIX_W*j +: TAPS*PIX_W]),
                .y_o (h_row[p][PIX_W*j +: PIX_W])
            );
        end
    end

    // Column j of buffer rows vrow..vrow+7, packed as filter taps.
    logic [ROW_W-1:0] col_t [3][BLK];
    logic [ROW_W-1:0] col_i [BLK];
    always_comb begin
        col_t = '{default: '0};
        col_i = '{default: '0};
        for (int j = 0; j < BLK; j++) begin
            for (int t = 0; t < TAPS; t++) begin
                for (int x = 0; x < 3; x++)
                    col_t[x][j][PIX_W*t +: PIX_W] =
                        temp_q[x][ROW_W*(int'(vrow) + t) + PIX_W*j +: PIX_W];
                col_i[j][PIX_W*t +: PIX_W] = ibuf_q[ROW_W*(int'(vrow) + t) + PIX_W*j +: PIX_W];
            end
        end
    end

    // v_t[x][p][j]: horizontal-X buffer filtered vertically with phase p.
    // v_i[x][j]:    integer buffer filtered vertically with phase x.
    logic [PIX_W-1:0] v_t [3][3][BLK];
    logic [PIX_W-1:0] v_i [3][BLK];
    for (genvar x = 0; x < 3; x++) begin : g_vsrc
        for (genvar j = 0; j < BLK; j++) begin : g_vcol
            for (genvar p = 0; p < 3; p++) begin : g_vph
                subpix_fir8 #(.PH(phase_e'(p))) u_fir (
                    .x_i (col_t[x][j]),
                    .y_o (v_t[x][p][j])
                );
            end
            subpix_fir8 #(.PH(phase_e'(x))) u_fir_int (
                .x_i (col_i[j]),
                .y_o (v_i[x][j])
            );
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        temp_d = temp_q;
        ibuf_d = ibuf_q;
        out_d  = out_q;
        cur_d  = cur_q;
        if (cnt_q < CNT_DONE)
            cnt_d = cnt_q + 8'd1;
        if (hphase) begin
            for (int p = 0; p < 3; p++)
                temp_d[p][ROW_W*int'(hrow) +: ROW_W] = h_row[p];
            // Integer-aligned samples are columns 3..10.
            ibuf_d[ROW_W*int'(hrow) +: ROW_W] = in_row[PIX_W*3 +: ROW_W];
            cur_d = in_row;
        end else if (vphase) begin
            for (int x = 0; x < 3; x++) begin
                out_d[x][ROW_W*int'(vrow) +: ROW_W] = temp_q[x][ROW_W*(int'(vrow) + 3) +: ROW_W];
                for (int j = 0; j < BLK; j++) begin
                    for (int p = 0; p < 3; p++)
                        out_d[x][BLOCK_W*(p+1) + ROW_W*int'(vrow) + PIX_W*j +: PIX_W] = v_t[x][p][j];
                    out_d[x][BLOCK_W*4 + ROW_W*int'(vrow) + PIX_W*j +: PIX_W] = v_i[x][j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            temp_q <= '{default: '0};
            ibuf_q <= '0;
            out_q  <= '{default: '0};
            cur_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            temp_q <= temp_d;
            ibuf_q <= ibuf_d;
            out_q  <= out_d;
            cur_q  <= cur_d;
        end
    end

    assign cnt           = cnt_q;
    assign next_row      = {60'd0, hrow};
    assign sel           = {4'd0, vrow};
    assign load_out      = (cnt_q == CNT_DONE);
    assign fir_out_a     = h_row[0];
    assign fir_out_b     = h_row[1];
    assign fir_out_c     = h_row[2];
    assign temp_A        = temp_q[0];
    assign temp_B        = temp_q[1];
    assign temp_C        = temp_q[2];
    assign out_A         = out_q[0];
    assign out_B         = out_q[1];
    assign out_C         = out_q[2];
    assign currentPixels = cur_q;
endmodule

// File: tb/tb_subpixel_interp_8x8.sv
// tb/tb_subpixel_interp_8x8.sv - scoreboard bench for subpixel_interp_8x8 against an arithmetic reference model
module tb_subpixel_interp_8x8;
    localparam int COEF [3][8] = '{'{-1, 4, -10, 58, 17,  -5, 1,  0},
                                   '{-1, 4, -11, 40, 40, -11, 4, -1},
                                   '{ 0, 1,  -5, 17, 58, -10, 4, -1}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [119:0]  in_row;
    logic [63:0]   next_row;
    logic [2559:0] out_A, out_B, out_C;
    logic [7:0]    cnt;
    logic [63:0]   fir_out_a, fir_out_b, fir_out_c;
    logic [959:0]  temp_A, temp_B, temp_C;
    logic          load_out;
    logic [7:0]    sel;
    logic [119:0]  currentPixels;

    subpixel_interp_8x8 dut (
        .clk(clk), .rst(rst), .in_row(in_row), .next_row(next_row),
        .out_A(out_A), .out_B(out_B), .out_C(out_C), .cnt(cnt),
        .fir_out_a(fir_out_a), .fir_out_b(fir_out_b), .fir_out_c(fir_out_c),
        .temp_A(temp_A), .temp_B(temp_B), .temp_C(temp_C),
        .load_out(load_out), .sel(sel), .currentPixels(currentPixels)
    );

    always #5 clk = ~clk;

    int pix [15][15];
    int hm  [3][15][8];

    always_comb begin
        int r;
        in_row = '0;
        r = int'(next_row[3:0]);
        if (next_row < 64'd15)
            for (int c = 0; c < 15; c++) in_row[8*c +: 8] = 8'(pix[r][c]);
    end

    typedef struct {
        logic [2:0][2559:0] o;
        logic [2:0][959:0]  t;
        logic [119:0]       cp;
    } exp_t;
    exp_t sbq [$];

    int n_cmp = 0, n_bad = 0, n_pop = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input int exp);
        check(name, 512'(act), 512'(exp));
    endtask

    function automatic int ref_fir(input int ph, input int v [8]);
        int s = 0;
        for (int t = 0; t < 8; t++) s += COEF[ph][t] * v[t];
        s = (s + 32) >>> 6;
        return (s < 0) ? 0 : (s > 255) ? 255 : s;
    endfunction

    task automatic build_model(output exp_t e);
        int v [8];
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 15; k++)
                for (int j = 0; j < 8; j++) begin
                    for (int t = 0; t < 8; t++) v[t] = pix[k][j+t];
                    hm[p][k][j] = ref_fir(p, v);
                end
        e.o = '0; e.t = '0; e.cp = '0;
        for (int x = 0; x < 3; x++) begin
            for (int k = 0; k < 15; k++)
                for (int j = 0; j < 8; j++) e.t[x][64*k + 8*j +: 8] = 8'(hm[x][k][j]);
            for (int r = 0; r < 8; r++)
                for (int j = 0; j < 8; j++) begin
                    e.o[x][64*r + 8*j +: 8] = 8'(hm[x][r+3][j]);
                    for (int p = 0; p < 3; p++) begin
                        for (int t = 0; t < 8; t++) v[t] = hm[x][r+t][j];
                        e.o[x][512*(p+1) + 64*r + 8*j +: 8] = 8'(ref_fir(p, v));
                    end
                    for (int t = 0; t < 8; t++) v[t] = pix[r+t][j+3];
                    e.o[x][2048 + 64*r + 8*j +: 8] = 8'(ref_fir(x, v));
                end
        end
        for (int c = 0; c < 15; c++) e.cp[8*c +: 8] = 8'(pix[14][c]);
    endtask

    function automatic logic [2559:0] dut_out(input int x);
        case (x) 0: return out_A; 1: return out_B; default: return out_C; endcase
    endfunction
    function automatic logic [959:0] dut_temp(input int x);
        case (x) 0: return temp_A; 1: return temp_B; default: return temp_C; endcase
    endfunction
    function automatic logic [63:0] dut_fir(input int x);
        case (x) 0: return fir_out_a; 1: return fir_out_b; default: return fir_out_c; endcase
    endfunction

    // Monitor: one scoreboard entry is consumed each time load_out rises.
    bit seen = 0;
    always @(negedge clk) begin
        exp_t e;
        logic [2559:0] o;
        logic [959:0]  tm;
        if (rst) seen = 0;
        else if (load_out && !seen) begin
            seen = 1;
            if (sbq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_load_out: got 1 expected 0");
            end else begin
                e = sbq.pop_front();
                for (int x = 0; x < 3; x++) begin
                    o  = dut_out(x);
                    tm = dut_temp(x);
                    for (int b = 0; b < 5; b++)
                        check($sformatf("out%0d_b%0d", x, b), o[512*b +: 512], e.o[x][512*b +: 512]);
                    for (int k = 0; k < 15; k++)
                        check($sformatf("temp%0d_r%0d", x, k), 512'(tm[64*k +: 64]), 512'(e.t[x][64*k +: 64]));
                end
                check("currentPixels", 512'(currentPixels), 512'(e.cp));
                n_pop++;
            end
        end
    end

    task automatic check_all_zero(input string name);
        logic [2559:0] o;
        logic [959:0]  tm;
        check({name, "_cnt"}, 512'(cnt), '0);
        check({name, "_next_row"}, 512'(next_row), '0);
        check({name, "_sel"}, 512'(sel), '0);
        check({name, "_load_out"}, 512'(load_out), '0);
        check({name, "_currentPixels"}, 512'(currentPixels), '0);
        for (int x = 0; x < 3; x++) begin
            o  = dut_out(x);
            tm = dut_temp(x);
            for (int b = 0; b < 5; b++) check($sformatf("%s_out%0d_b%0d", name, x, b), o[512*b +: 512], '0);
            for (int k = 0; k < 15; k++) check($sformatf("%s_temp%0d_r%0d", name, x, k), 512'(tm[64*k +: 64]), '0);
        end
    endtask

    // k = rising edges since reset release.
    task automatic ctrl_check(input string name, input int k);
        logic [63:0] f;
        check($sformatf("%s_cnt@%0d", name, k), 512'(cnt), 512'((k < 23) ? k : 23));
        check($sformatf("%s_next_row@%0d", name, k), 512'(next_row), 512'((k < 14) ? k : 14));
        check($sformatf("%s_sel@%0d", name, k), 512'(sel), 512'((k >= 15 && k <= 22) ? k - 15 : 0));
        check($sformatf("%s_load_out@%0d", name, k), 512'(load_out), 512'(k >= 23));
        if (k < 15)
            for (int x = 0; x < 3; x++) begin
                f = '0;
                for (int j = 0; j < 8; j++) f[8*j +: 8] = 8'(hm[x][k][j]);
                check($sformatf("%s_fir%0d@%0d", name, x, k), 512'(dut_fir(x)), 512'(f));
            end
    endtask

    task automatic run_block(input string name, input int abort_at);
        exp_t e;
        int   want;
        build_model(e);
        if (abort_at < 0) sbq.push_back(e);
        want = n_pop + ((abort_at < 0) ? 1 : 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk);
            #1;
            ctrl_check(name, k);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_all_zero({name, "_abort"});
                return;
            end
        end
        for (int i = 0; i < 4 && n_pop < want; i++) @(negedge clk);
        #1;
        n_cmp++;
        if (n_pop < want) begin
            n_bad++;
            $display("FAIL %s_scoreboard_timeout: got %0d results expected %0d", name, n_pop, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                case (mode)
                    0: pix[r][c] = 0;
                    1: pix[r][c] = 100;
                    2: pix[r][c] = 10 * c;
                    3: pix[r][c] = (c % 2 == 0) ? 255 : 0;
                    default: pix[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    initial begin
        fill(0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        fill(1);
        run_block("flat", -1);
        check8("flat_A_b0", out_A[7:0], 100);
        check8("flat_B_b2_r3_c3", out_B[1024 + 192 + 24 +: 8], 100);
        check8("flat_C_b4_r7_c7", out_C[2048 + 448 + 56 +: 8], 100);
        do_reset();

        fill(2);
        run_block("ramp", -1);
        for (int j = 0; j < 8; j++) begin
            check8($sformatf("ramp_B_b0_c%0d", j), out_B[8*j +: 8], 10*j + 35);
            check8($sformatf("ramp_A_b4_c%0d", j), out_A[2048 + 8*j +: 8], 10*j + 30);
        end
        do_reset();

        fill(3);
        run_block("alt", -1);
        check8("alt_B_c0", out_B[7:0], 128);
        check8("alt_B_c2", out_B[23:16], 128);
        check8("alt_A_c0", out_A[7:0], 28);
        check8("alt_A_c1", out_A[15:8], 227);
        do_reset();

        fill(0);
        pix[7][7] = 255;
        run_block("impulse", -1);
        check8("impulse_B_b2_r3_c3", out_B[1024 + 192 + 24 +: 8], 99);
        check8("impulse_B_b2_r0_c3", out_B[1024 + 24 +: 8], 0);
        do_reset();

        fill(4);
        run_block("rand_abort", 18);
        run_block("rand_after_abort", -1);
        do_reset();

        fill(4);
        run_block("rand2", -1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
